// File: rtl/adder_share_pkg.sv
// Shared types and constants for the adder-sharing controller.
// Imported by the arbiter and the top level.
package adder_share_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  localparam int DEF_WIDTH   = 64;
  localparam int DEF_TIMEOUT = 255;
  localparam int MAX_NREQ    = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
// Rotates the request vector so a plain priority scan finds the winner.
import adder_share_pkg::*;

module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [IW:0]     sum;

  // rotate, take lowest set bit, map back to an absolute index
  always_comb begin
    rot   = NREQ'({req, req} >> ptr);
    any   = |rot;
    sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) sum = {1'b0, ptr} + (IW+1)'(k);
    end
    if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
    idx   = sum[IW-1:0];
    grant = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one serial adder among NREQ requesters via round-robin.
// Optional watchdog on adder done: define ADDER_TIMEOUT_EN.
import adder_share_pkg::*;

module adder_share_ctrl #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  cirCLK,
  input  logic                  cirRST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] reqA,
  input  logic [NREQ*WIDTH-1:0] reqB,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      resOut,
  output logic                  coutOut,
  output logic                  err,
  output logic                  busy,
  output logic                  addStart,
  output logic [WIDTH-1:0]      addA,
  output logic [WIDTH-1:0]      addB,
  input  logic                  addDone,
  input  logic [WIDTH-1:0]      addResult,
  input  logic                  addCarry
);

  localparam int IW = idx_w(NREQ);

  if (NREQ < 1 || NREQ > MAX_NREQ || TIMEOUT < 1) begin : g_bad_cfg
    $error("adder_share_ctrl: illegal NREQ or TIMEOUT");
  end

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   g_idx;
  logic [NREQ-1:0] g_oh;
  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            seen_low;
  logic            done_ok;
  logic            expire;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_oh),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // a level done only counts once it has been seen low in this op
  assign done_ok = (state == WAIT) && addDone && seen_low;

`ifdef ADDER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ?
                      $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] wd_cnt;

  // limit hits when this WAIT cycle brings the count to TIMEOUT
  assign expire = (state == WAIT) && !done_ok &&
                  (wd_cnt == CW'(TIMEOUT - 1));

  // watchdog: cleared on launch, counts WAIT cycles
  always_ff @(posedge cirCLK) begin
    if (cirRST)               wd_cnt <= '0;
    else if (state == LAUNCH) wd_cnt <= '0;
    else if (state == WAIT)   wd_cnt <= wd_cnt + 1'b1;
  end

  // error flag travels with the response
  always_ff @(posedge cirCLK) begin
    if (cirRST)       err <= 1'b0;
    else if (done_ok) err <= 1'b0;
    else if (expire)  err <= 1'b1;
  end
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  // state register
  always_ff @(posedge cirCLK) begin
    if (cirRST) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and per-state strobes
  always_comb begin
    state_nx = state;
    addStart = 1'b0;
    ack      = '0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE:    if (arb_any) state_nx = LAUNCH;
      LAUNCH: begin
        addStart = 1'b1;
        state_nx = WAIT;
      end
      WAIT:    if (done_ok || expire) state_nx = RESP;
      RESP: begin
        ack      = g_oh;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // grant, operand, stale-done and result registers
  always_ff @(posedge cirCLK) begin
    if (cirRST) begin
      ptr      <= '0;
      g_idx    <= '0;
      g_oh     <= '0;
      addA     <= '0;
      addB     <= '0;
      resOut   <= '0;
      coutOut  <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      if (state == IDLE && arb_any) begin
        g_idx <= arb_idx;
        g_oh  <= arb_oh;
        addA  <= reqA[int'(arb_idx)*WIDTH +: WIDTH];
        addB  <= reqB[int'(arb_idx)*WIDTH +: WIDTH];
      end
      if (state == LAUNCH)
        seen_low <= 1'b0;
      else if (state == WAIT && !addDone)
        seen_low <= 1'b1;
      if (done_ok) begin
        resOut  <= addResult;
        coutOut <= addCarry;
      end else if (expire) begin
        resOut  <= '0;
        coutOut <= 1'b0;
      end
      if (state == RESP) begin
        if (g_idx == IW'(NREQ - 1)) ptr <= '0;
        else                        ptr <= g_idx + 1'b1;
      end
    end
  end

endmodule
